// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the EXE-stage multiply sequencer: word/address
// widths and the sequencer state encoding.
package mul_sequencer_pkg;

  localparam int WORD_LEN          = 16;
  localparam int REG_FILE_ADDR_LEN = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// EXE-stage <-> multiply sequencer signal bundle. The pipeline side is the
// master; the sequencer is the slave.
interface mul_sequencer_if
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH  = WORD_LEN,
  parameter int ADDR_W = REG_FILE_ADDR_LEN
);

  logic              mul_en;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [ADDR_W-1:0] dest_in;
  logic              freeze;
  logic              busy;
  logic [WIDTH-1:0]  result_lo;
  logic [WIDTH-1:0]  result_hi;
  logic              result_valid;
  logic [ADDR_W-1:0] dest_out;

  modport master (
    output mul_en, op_a, op_b, dest_in,
    input  freeze, busy, result_lo, result_hi, result_valid, dest_out
  );

  modport slave (
    input  mul_en, op_a, op_b, dest_in,
    output freeze, busy, result_lo, result_hi, result_valid, dest_out
  );

endinterface

// File: rtl/mul_sequencer_shift_add_dp.sv
// Shift-add multiplier datapath: accumulator, shifting multiplicand and
// multiplier, driven by load/step strobes from the sequencer.
module mul_shift_add_dp
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = WORD_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] acc,
  output logic               mplier_zero
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, op_a};
      mplier <= op_b;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Looks ahead: true when the multiplier is zero once this step's shift lands.
  assign mplier_zero = (mplier[WIDTH-1:1] == '0);

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer for EXE: freezes IF/ID/EXE while the
// shift-add datapath runs. MUL_EARLY_EXIT_EN enables data-dependent early exit.
//
// state | meaning
// IDLE  | waiting for MUL_EN; loads operands when it is seen
// RUN   | one multiplier bit per cycle, pipeline frozen
// DONE  | product valid for one cycle, MUL advances to MEM
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH  = WORD_LEN,
  parameter int ADDR_W = REG_FILE_ADDR_LEN
) (
  input  logic            clk,
  input  logic            rst,
  mul_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  mul_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  dest_q;
  logic [2*WIDTH-1:0] acc;
  logic               load, step, mplier_zero, last_iter;

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .op_a        (bus.op_a),
    .op_b        (bus.op_b),
    .acc         (acc),
    .mplier_zero (mplier_zero)
  );

  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (EARLY_EXIT && mplier_zero);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dest_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt    <= '0;
        dest_q <= bus.dest_in;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mul_en) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst so a held MUL_EN cannot stall the pipeline during reset.
  assign bus.freeze       = rst && (((state == IDLE) && bus.mul_en) || (state == RUN));
  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.result_lo    = acc[WIDTH-1:0];
  assign bus.result_hi    = acc[2*WIDTH-1:WIDTH];
  assign bus.dest_out     = dest_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized self-checking bench for mul_sequencer against a product/latency
// reference model.
module tb_mul_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mul_sequencer_if bus ();

  mul_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Number of RUN cycles the spec predicts for a given multiplier.
  function automatic int exp_run(input logic [15:0] b);
    int r;
`ifdef MUL_EARLY_EXIT_EN
    r = 1;
    for (int i = 0; i < 16; i++) if (b[i]) r = i + 1;
`else
    r = 16;
`endif
    return r;
  endfunction

  // Drives a MUL into the current (IDLE) cycle, runs to DONE and checks it.
  // Returns sitting in the DONE cycle with mul_en still high.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, input int chg_cyc);
    logic [31:0] p;
    int cyc, frz, run;
    bit done;
    p   = {16'd0, a} * {16'd0, b};
    run = exp_run(b);
    bus.mul_en  = 1'b1;
    bus.op_a    = a;
    bus.op_b    = b;
    bus.dest_in = d;
    #1;
    cyc  = 0;
    frz  = 0;
    done = 0;
    while (!done && cyc < 40) begin
      if (bus.result_valid) begin
        done = 1;
      end else begin
        if (bus.freeze) frz++;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == chg_cyc) begin
          bus.op_b    = 16'd0;
          bus.op_a    = 16'($urandom);
          bus.dest_in = 4'($urandom);
        end
      end
    end
    chk("done_cycle", cyc, run + 1);
    chk("freeze_cycles", frz, run + 1);
    chk("result_lo", bus.result_lo, p[15:0]);
    chk("result_hi", bus.result_hi, p[31:16]);
    chk("dest_out", bus.dest_out, d);
    chk("freeze_in_done", bus.freeze, 0);
    chk("busy_in_done", bus.busy, 1);
  endtask

  // Drops mul_en in DONE and checks the following idle cycle.
  task automatic post_done(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, b};
    bus.mul_en = 1'b0;
    @(posedge clk);
    #1;
    chk("valid_one_cycle", bus.result_valid, 0);
    chk("busy_after", bus.busy, 0);
    chk("freeze_after", bus.freeze, 0);
    chk("hold_lo", bus.result_lo, p[15:0]);
    chk("hold_hi", bus.result_hi, p[31:16]);
  endtask

  initial begin
    logic [15:0] a, b, mask;
    logic [3:0]  d;
    int sh;

    bus.mul_en  = 1'b1;
    bus.op_a    = 16'h1234;
    bus.op_b    = 16'h5678;
    bus.dest_in = 4'd6;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_freeze", bus.freeze, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_lo", bus.result_lo, 0);
    chk("rst_hi", bus.result_hi, 0);
    chk("rst_dest", bus.dest_out, 0);
    bus.mul_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_mul(16'd3, 16'd5, 4'd7, 0);
    post_done(16'd3, 16'd5);

    do_mul(16'hFFFF, 16'hFFFF, 4'd2, 0);
    post_done(16'hFFFF, 16'hFFFF);

    do_mul(16'd7, 16'd9, 4'd3, 0);
    @(posedge clk);
    #1;
    do_mul(16'h0100, 16'h0100, 4'd4, 0);
    post_done(16'h0100, 16'h0100);

    do_mul(16'h1234, 16'h00F7, 4'd9, 5);
    post_done(16'h1234, 16'h00F7);

    do_mul(16'd1234, 16'd1, 4'd1, 0);
    post_done(16'd1234, 16'd1);
    do_mul(16'hBEEF, 16'h8000, 4'd8, 0);
    post_done(16'hBEEF, 16'h8000);
    do_mul(16'hBEEF, 16'h0000, 4'd15, 0);
    post_done(16'hBEEF, 16'h0000);

    // Reset in the middle of RUN with mul_en still high.
    bus.mul_en  = 1'b1;
    bus.op_a    = 16'h0F0F;
    bus.op_b    = 16'hABCD;
    bus.dest_in = 4'd11;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_freeze", bus.freeze, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_valid", bus.result_valid, 0);
    chk("midrst_lo", bus.result_lo, 0);
    chk("midrst_hi", bus.result_hi, 0);
    chk("midrst_dest", bus.dest_out, 0);
    @(negedge clk);
    rst = 1'b1;
    do_mul(16'h55AA, 16'hABCD, 4'd5, 0);
    post_done(16'h55AA, 16'hABCD);

    for (int i = 0; i < 20; i++) begin
      a    = 16'($urandom);
      sh   = $urandom_range(0, 16);
      mask = 16'((32'd1 << sh) - 1);
      b    = 16'($urandom) & mask;
      d    = 4'($urandom);
      do_mul(a, b, d, ($urandom_range(0, 3) == 0) ? 3 : 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end else begin
        post_done(a, b);
      end
    end
    bus.mul_en = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      bus.op_a    = 16'($urandom);
      bus.op_b    = 16'($urandom);
      bus.dest_in = 4'($urandom);
      @(posedge clk);
      #1;
      chk("idle_stream", {bus.freeze, bus.busy}, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
